// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multi-nibble ALU sequencer: ALU Select encodings,
// sequencer FSM states and the carry-chaining predicate.
package alu_seq_pkg;

  localparam logic [2:0] OP_NOT_A = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b101;
  localparam logic [2:0] OP_ZERO  = 3'b110;
  localparam logic [2:0] OP_ONE   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Only add and rotate pass a carry from one nibble into the next.
  function automatic logic chains_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/result bus plus the 4-bit ALU side-channel of the sequencer.
// Optional macro ALU_SEQ_ZERO_FLAG_EN adds the registered zero flag.
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic           start;
  logic [2:0]     op;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           cin;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           cout;
  logic [2:0]     alu_select;
  logic [3:0]     alu_a;
  logic [3:0]     alu_b;
  logic           alu_c;
  logic [3:0]     alu_regout;
  logic           alu_carryout;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic           zero;

  modport master (
    output start, op, opa, opb, cin, alu_regout, alu_carryout,
    input  busy, done, result, cout, alu_select, alu_a, alu_b, alu_c, zero
  );
  modport slave (
    input  start, op, opa, opb, cin, alu_regout, alu_carryout,
    output busy, done, result, cout, alu_select, alu_a, alu_b, alu_c, zero
  );
`else
  modport master (
    output start, op, opa, opb, cin, alu_regout, alu_carryout,
    input  busy, done, result, cout, alu_select, alu_a, alu_b, alu_c
  );
  modport slave (
    input  start, op, opa, opb, cin, alu_regout, alu_carryout,
    output busy, done, result, cout, alu_select, alu_a, alu_b, alu_c
  );
`endif

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Issues a wide operation to a 4-bit registered ALU nibble by nibble (LSB first),
// chains carry for ADD/ROL and reassembles the result. Macro: ALU_SEQ_ZERO_FLAG_EN.
module alu_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  alu_nibble_sequencer_if.slave  bus
);

  localparam int W   = 4 * NIBBLES;
  localparam int KW  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(NIBBLES - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(ALU_LAT - 1);

  seq_state_e     state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2:0]     alu_select_q, alu_select_d;
  logic [3:0]     alu_a_q, alu_a_d;
  logic [3:0]     alu_b_q, alu_b_d;
  logic           alu_c_q, alu_c_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic           zero_q, zero_d;
`endif

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    wcnt_d       = wcnt_q;
    op_d         = op_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    result_d     = result_q;
    cout_d       = cout_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    alu_select_d = alu_select_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_c_d      = alu_c_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    zero_d       = zero_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          // ALU inputs are registered here so they are already valid in ISSUE.
          op_d         = bus.op;
          opa_d        = bus.opa;
          opb_d        = bus.opb;
          k_d          = '0;
          busy_d       = 1'b1;
          alu_select_d = bus.op;
          alu_a_d      = bus.opa[3:0];
          alu_b_d      = bus.opb[3:0];
          alu_c_d      = chains_carry(bus.op) ? bus.cin : 1'b0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == W_LAST) begin
          result_d[k_q*4 +: 4] = bus.alu_regout;
          cout_d = chains_carry(op_q) ? bus.alu_carryout : 1'b0;
          if (k_q == K_LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_d  = (result_d == '0);
`endif
          end else begin
            k_d     = k_q + 1'b1;
            alu_a_d = opa_q[k_d*4 +: 4];
            alu_b_d = opb_q[k_d*4 +: 4];
            alu_c_d = chains_carry(op_q) ? bus.alu_carryout : 1'b0;
            state_d = ST_ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      wcnt_q       <= '0;
      op_q         <= '0;
      opa_q        <= '0;
      opb_q        <= '0;
      result_q     <= '0;
      cout_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      alu_select_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_c_q      <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      wcnt_q       <= wcnt_d;
      op_q         <= op_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      result_q     <= result_d;
      cout_q       <= cout_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      alu_select_q <= alu_select_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_c_q      <= alu_c_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_q       <= zero_d;
`endif
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.cout       = cout_q;
  assign bus.alu_select = alu_select_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_c      = alu_c_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  assign bus.zero       = zero_q;
`endif

endmodule
